piple_delay_var: RTL and testbench

//   Parametrised multi-bit pipeline delay line with a runtime-selectable depth (0..MAX_DLY).

---
 rtl/piple_delay_var.sv | 93 +++++++++
 tb/tb_piple_delay_var.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piple_delay_var.sv
// piple_delay_var: multi-bit pipeline delay line with a runtime-selectable depth.
// Carries a valid flag alongside the data and supports a stall (en) and a flush.
// Depth selection clamps to MAX_DLY; a depth of 0 is a combinational pass-through.
// Optional feature macro: PIPE_DLY_EDGE_EN adds the per-bit edge detect outputs
// rise_o and fall_o.
module piple_delay_var #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_DLY = 16,
  parameter int unsigned SEL_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] dly_sel,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
`ifdef PIPE_DLY_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);

  // Stage k holds the word accepted k advancing edges ago.
  logic [MAX_DLY:1]   v_q;
  logic [WIDTH-1:0]   d_q [1:MAX_DLY];
  logic [31:0]        dly_eff;

  // Shift chain: flush clears, en advances, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned k = 1; k <= MAX_DLY; k++) d_q[k] <= '0;
    end else if (flush) begin
      v_q <= '0;
      for (int unsigned k = 1; k <= MAX_DLY; k++) d_q[k] <= '0;
    end else if (en) begin
      v_q[1] <= valid_i;
      d_q[1] <= data_i;
      for (int unsigned k = 2; k <= MAX_DLY; k++) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
      end
    end
  end

  // Clamp the requested depth to the number of physical stages.
  always_comb begin
    dly_eff = 32'(dly_sel);
    if (dly_eff > MAX_DLY) dly_eff = MAX_DLY;
  end

  // Output tap: depth 0 passes the inputs straight through.
  always_comb begin
    valid_o = valid_i;
    data_o  = data_i;
    for (int unsigned k = 1; k <= MAX_DLY; k++) begin
      if (dly_eff == k) begin
        valid_o = v_q[k];
        data_o  = d_q[k];
      end
    end
  end

`ifdef PIPE_DLY_EDGE_EN
  logic [WIDTH-1:0] prev_q;

  // Remember the last output word seen on an advancing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (flush) begin
      prev_q <= '0;
    end else if (en) begin
      prev_q <= data_o;
    end
  end

  // Per-bit edges of data_o, suppressed while the output word is invalid.
  always_comb begin
    rise_o = '0;
    fall_o = '0;
    if (valid_o) begin
      rise_o = data_o & ~prev_q;
      fall_o = ~data_o & prev_q;
    end
  end
`endif

endmodule

// File: tb/tb_piple_delay_var.sv
// Self-checking bench for piple_delay_var (WIDTH=8, MAX_DLY=16, SEL_W=5).
// A history-of-words model predicts the outputs every cycle; directed
// sections pin the model with hand-computed values.
module tb_piple_delay_var;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_DLY = 16;
  localparam int unsigned SEL_W   = 5;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic             flush = 1'b0;
  logic [SEL_W-1:0] dly_sel = '0;
  logic             valid_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
`ifdef PIPE_DLY_EDGE_EN
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  piple_delay_var #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .flush(flush),
    .dly_sel(dly_sel),
    .valid_i(valid_i),
    .data_i(data_i),
    .valid_o(valid_o),
    .data_o(data_o)
`ifdef PIPE_DLY_EDGE_EN
    ,
    .rise_o(rise_o),
    .fall_o(fall_o)
`endif
  );

  always #5 clk = ~clk;

  // Model: newest-first history of accepted words; missing history reads as zero.
  word_t            hist[$];
  logic [WIDTH-1:0] prev_m = '0;

  function automatic word_t model_out();
    int unsigned dd;
    word_t w;
    dd = (int'(dly_sel) > int'(MAX_DLY)) ? MAX_DLY : int'(dly_sel);
    w.v = valid_i;
    w.d = data_i;
    if (dd == 0) return w;
    if (hist.size() < dd) return '0;
    return hist[dd-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      hist.delete();
      prev_m = '0;
    end else if (en) begin
      word_t w;
      prev_m = model_out().d;
      w.v = valid_i;
      w.d = data_i;
      hist.push_front(w);
      if (hist.size() > MAX_DLY) void'(hist.pop_back());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      word_t e;
      e = model_out();
      check("model_valid_o", 32'(valid_o), 32'(e.v));
      check("model_data_o", 32'(data_o), 32'(e.d));
`ifdef PIPE_DLY_EDGE_EN
      check("model_rise_o", 32'(rise_o), e.v ? 32'(e.d & ~prev_m) : 32'd0);
      check("model_fall_o", 32'(fall_o), e.v ? 32'(~e.d & prev_m) : 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  logic [11:0] obs;
  logic [5:0]  rise_obs, fall_obs;

  initial begin
    // Reset state with a nonzero depth: outputs are zero.
    dly_sel = 5'd3;
    #3;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_data_o", 32'(data_o), 32'd0);
    // Depth 0 passes through combinationally, even in reset.
    dly_sel = 5'd0; valid_i = 1'b1; data_i = 8'hA5;
    #1;
    check("pass_data_o", 32'(data_o), 32'hA5);
    check("pass_valid_o", 32'(valid_o), 32'd1);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Depth 5, bit0 pattern 1,1,0,0,1,1 re-appears 2-2-2 after the pipe delay.
    dly_sel = 5'd5;
    do_flush();
    obs = '0;
    for (int k = 1; k <= 12; k++) begin
      data_i = (k <= 6 && (k != 3 && k != 4)) ? 8'h01 : 8'h00;
      step();
      obs[k-1] = data_o[0];
    end
    check("pattern_d5", 32'(obs), 32'h330);

    // Clamp: depth 20 behaves as 16 on a ramp.
    dly_sel = 5'd20;
    do_flush();
    valid_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      data_i = 8'(k - 1);
      step();
      if (k == 15) check("clamp_valid_pre", 32'(valid_o), 32'd0);
      if (k == 16) begin
        check("clamp_valid_rise", 32'(valid_o), 32'd1);
        check("clamp_data_first", 32'(data_o), 32'd0);
      end
      if (k == 20) check("clamp_data_lag16", 32'(data_o), 32'd4);
    end

    // Stall: depth 4, en low for 3 edges freezes the output.
    dly_sel = 5'd4;
    do_flush();
    for (int k = 1; k <= 10; k++) begin
      data_i = 8'(k - 1);
      step();
    end
    check("stall_before", 32'(data_o), 32'd6);
    en = 1'b0;
    data_i = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_frozen", 32'(data_o), 32'd6);
    end
    en = 1'b1;
    data_i = 8'd10;
    step();
    check("stall_resume", 32'(data_o), 32'd7);

    // Flush of a full valid pipe empties it; new words surface after D edges.
    do_flush();
    check("flush_valid_o", 32'(valid_o), 32'd0);
    check("flush_data_o", 32'(data_o), 32'd0);
    data_i = 8'h55;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check("flush_still_empty", 32'(valid_o), 32'd0);
    end
    check("flush_new_data", 32'(data_o), 32'h55);
    check("flush_new_valid", 32'(valid_o), 32'd1);

`ifdef PIPE_DLY_EDGE_EN
    // Depth 2, bit0 pattern 0,1,1,0: one rise pulse, one fall pulse.
    dly_sel = 5'd2;
    do_flush();
    rise_obs = '0;
    fall_obs = '0;
    for (int k = 1; k <= 6; k++) begin
      data_i = (k == 2 || k == 3) ? 8'h01 : 8'h00;
      step();
      rise_obs[k-1] = rise_o[0];
      fall_obs[k-1] = fall_o[0];
    end
    check("edge_rise", 32'(rise_obs), 32'h04);
    check("edge_fall", 32'(fall_obs), 32'h10);
`endif

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    dly_sel = 5'd3;
    data_i = 8'hAA;
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_data", 32'(data_o), 32'd0);
    step();
    rst_n = 1'b1;

    // Randomized traffic with depth changes, stalls, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom % 8) != 0;
      flush   = ($urandom % 50) == 0;
      valid_i = $urandom % 2;
      data_i  = 8'($urandom);
      if (($urandom % 40) == 0) dly_sel = 5'($urandom % 32);
      if (($urandom % 500) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      step();
    end
    flush = 1'b0;
    en = 1'b1;
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
